hpi_responder: RTL and testbench

- Slave (chip-side) end of the EZ-OTG Host Port Interface (HPI) that the Nios system drives through its otg_hpi_* PIO exports.
- Implements the four HPI registers (DATA, MAILBOX, ADDRESS, STATUS) over an internal 16-bit word RAM, with address auto-increment and a bidirectional mailbox.
- Used as an on-chip stand-in for the USB controller, for bring-up and simulation of the host-side HPI driver, and as a Nios-to-fabric message channel.

---
 rtl/hpi_responder.sv | 155 +++++++++++++++
 tb/tb_hpi_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hpi_responder.sv
// HPI slave: DATA/MAILBOX/ADDRESS/STATUS registers over a 16-bit word RAM.
// Optional mailbox-overrun sticky status bit enabled by defining HPI_MBX_OVERRUN_EN.
module hpi_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int INC_BYTES  = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  hpi_address,
    input  logic        hpi_cs_n,
    input  logic        hpi_r_n,
    input  logic        hpi_w_n,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    output logic        hpi_int,
    output logic [15:0] mbx_in_data,
    output logic        mbx_in_pending,
    input  logic        mbx_in_ack,
    input  logic [15:0] mbx_out_data,
    input  logic        mbx_out_wr,
    output logic        mbx_out_full
);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MBX  = 2'd1;
    localparam logic [1:0] REG_ADDR = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;
    localparam logic [15:0] INC = 16'(INC_BYTES);

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [15:0] ram_rdata;

    logic        rd_act, wr_act, rd_q, wr_q, armed;
    logic        rd_start, wr_start, rd_end;
    logic [1:0]  rd_reg;
    logic [15:0] addr, addr_nxt;
    logic [DEPTH_LOG2-1:0] addr_word;
    logic [15:0] mbx_out_q;
    logic [15:0] out_q;
    logic        src_ram;
    logic        oe_nxt, full_nxt, pend_nxt, ovr, ovr_nxt, int_q;
    logic [15:0] status;
    logic        addr_unused;

    assign addr_word   = addr[DEPTH_LOG2:1];
    assign addr_unused = ^{addr[0], addr[15:DEPTH_LOG2+1]};

    assign rd_act = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
    assign wr_act = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;

    // armed blocks a strobe still held across reset release from counting as a start
    assign rd_start = rd_act && !rd_q && armed;
    assign wr_start = wr_act && !wr_q && armed;
    assign rd_end   = !rd_act && rd_q && hpi_data_oe;

    assign status = {13'd0, ovr, mbx_in_pending, mbx_out_full};

    always_comb begin
        addr_nxt = addr;
        if (rd_end && rd_reg == REG_DATA)
            addr_nxt = addr_nxt + INC;
        if (wr_start) begin
            case (hpi_address)
                REG_DATA: addr_nxt = addr_nxt + INC;
                REG_ADDR: addr_nxt = hpi_data_in;
                default:  ;
            endcase
        end

        oe_nxt = hpi_data_oe;
        if (rd_end)
            oe_nxt = 1'b0;
        if (rd_start)
            oe_nxt = 1'b1;

        // fabric write wins over a coinciding host mailbox read end
        full_nxt = mbx_out_full;
        if (rd_end && rd_reg == REG_MBX)
            full_nxt = 1'b0;
        if (mbx_out_wr)
            full_nxt = 1'b1;

        pend_nxt = mbx_in_pending;
        if (mbx_in_ack)
            pend_nxt = 1'b0;
        if (wr_start && hpi_address == REG_MBX)
            pend_nxt = 1'b1;

`ifdef HPI_MBX_OVERRUN_EN
        ovr_nxt = ovr;
        if (wr_start && hpi_address == REG_STAT && hpi_data_in[2])
            ovr_nxt = 1'b0;
        if (wr_start && hpi_address == REG_MBX && mbx_in_pending)
            ovr_nxt = 1'b1;
`else
        ovr_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            armed          <= 1'b0;
            rd_q           <= 1'b0;
            wr_q           <= 1'b0;
            addr           <= 16'd0;
            rd_reg         <= REG_DATA;
            out_q          <= 16'd0;
            src_ram        <= 1'b0;
            hpi_data_oe    <= 1'b0;
            int_q          <= 1'b0;
            mbx_in_data    <= 16'd0;
            mbx_in_pending <= 1'b0;
            mbx_out_full   <= 1'b0;
            mbx_out_q      <= 16'd0;
            ovr            <= 1'b0;
        end else begin
            armed          <= 1'b1;
            rd_q           <= rd_act;
            wr_q           <= wr_act;
            addr           <= addr_nxt;
            hpi_data_oe    <= oe_nxt;
            mbx_in_pending <= pend_nxt;
            mbx_out_full   <= full_nxt;
            ovr            <= ovr_nxt;
            int_q          <= full_nxt | ovr_nxt;
            if (mbx_out_wr)
                mbx_out_q <= mbx_out_data;
            if (wr_start && hpi_address == REG_MBX)
                mbx_in_data <= hpi_data_in;
            if (rd_start) begin
                rd_reg  <= hpi_address;
                src_ram <= (hpi_address == REG_DATA);
                case (hpi_address)
                    REG_MBX:  out_q <= mbx_out_q;
                    REG_ADDR: out_q <= addr;
                    REG_STAT: out_q <= status;
                    default:  out_q <= out_q;
                endcase
            end
        end
    end

    // Single-port RAM; read captured only at a DATA read start so the output holds afterwards
    always_ff @(posedge clk_clk) begin
        if (wr_start && hpi_address == REG_DATA)
            mem[addr_word] <= hpi_data_in;
        if (rd_start && hpi_address == REG_DATA)
            ram_rdata <= mem[addr_word];
    end

    assign hpi_data_out = src_ram ? ram_rdata : out_q;
    assign hpi_int      = int_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed self-checking bench for hpi_responder (default or HPI_MBX_OVERRUN_EN build).
module tb_hpi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  hpi_address = 2'd0;
    logic        hpi_cs_n = 1'b1, hpi_r_n = 1'b1, hpi_w_n = 1'b1;
    logic [15:0] hpi_data_in = 16'd0;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe, hpi_int;
    logic [15:0] mbx_in_data;
    logic        mbx_in_pending, mbx_out_full;
    logic        mbx_in_ack = 1'b0;
    logic [15:0] mbx_out_data = 16'd0;
    logic        mbx_out_wr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

    always #5 clk = ~clk;

    hpi_responder dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .hpi_address    (hpi_address),
        .hpi_cs_n       (hpi_cs_n),
        .hpi_r_n        (hpi_r_n),
        .hpi_w_n        (hpi_w_n),
        .hpi_data_in    (hpi_data_in),
        .hpi_data_out   (hpi_data_out),
        .hpi_data_oe    (hpi_data_oe),
        .hpi_int        (hpi_int),
        .mbx_in_data    (mbx_in_data),
        .mbx_in_pending (mbx_in_pending),
        .mbx_in_ack     (mbx_in_ack),
        .mbx_out_data   (mbx_out_data),
        .mbx_out_wr     (mbx_out_wr),
        .mbx_out_full   (mbx_out_full)
    );

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
        repeat (hold) @(negedge clk);
        hpi_w_n = 1'b1; hpi_cs_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d,
                            output logic oe_during, output logic oe_after);
        @(negedge clk);
        hpi_address = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        @(negedge clk);
        d = hpi_data_out; oe_during = hpi_data_oe;
        @(negedge clk);
        hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
        @(negedge clk);
        oe_after = hpi_data_oe;
    endtask

    task automatic pulse_out(input logic [15:0] d);
        @(negedge clk);
        mbx_out_data = d; mbx_out_wr = 1'b1;
        @(negedge clk);
        mbx_out_wr = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d; logic oe1, oe2;
        n_tests++; if (hpi_data_oe !== 1'b0) begin $display("FAIL reset_oe got %b exp 0", hpi_data_oe); n_fail++; end
        n_tests++; if (hpi_int !== 1'b0) begin $display("FAIL reset_int got %b exp 0", hpi_int); n_fail++; end
        n_tests++; if ({mbx_in_pending, mbx_out_full, mbx_in_data, hpi_data_out} !== 34'd0) begin
            $display("FAIL reset_outs got %b %b %h %h exp 0", mbx_in_pending, mbx_out_full, mbx_in_data, hpi_data_out); n_fail++; end
        bus_read(A_STAT, d, oe1, oe2);
        n_tests++; if (d !== 16'h0000) begin $display("FAIL reset_status got %h exp 0000", d); n_fail++; end
        n_tests++; if (oe1 !== 1'b1 || oe2 !== 1'b0) begin $display("FAIL read_oe got %b%b exp 10", oe1, oe2); n_fail++; end
    endtask

    task automatic test_data_autoinc;
        logic [15:0] d; logic oe1, oe2;
        logic [15:0] exp_v [3] = '{16'hAAAA, 16'h5555, 16'h1234};
        bus_write(A_ADDR, 16'h0100, 1);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, exp_v[i], 1);
        bus_read(A_ADDR, d, oe1, oe2);
        n_tests++; if (d !== 16'h0106) begin $display("FAIL autoinc_addr got %h exp 0106", d); n_fail++; end
        bus_write(A_ADDR, 16'h0100, 1);
        for (int i = 0; i < 3; i++) begin
            bus_read(A_DATA, d, oe1, oe2);
            n_tests++; if (d !== exp_v[i]) begin $display("FAIL data_rd%0d got %h exp %h", i, d, exp_v[i]); n_fail++; end
        end
        n_tests++; if (hpi_data_out !== 16'h1234) begin $display("FAIL out_hold got %h exp 1234", hpi_data_out); n_fail++; end
        bus_write(A_ADDR, 16'h0101, 1);
        bus_read(A_DATA, d, oe1, oe2);
        n_tests++; if (d !== 16'hAAAA) begin $display("FAIL addr_bit0 got %h exp AAAA", d); n_fail++; end
    endtask

    task automatic test_long_write_wrap;
        logic [15:0] d; logic oe1, oe2;
        bus_write(A_ADDR, 16'h0202, 1);
        bus_write(A_DATA, 16'h1111, 1);
        bus_write(A_ADDR, 16'h0200, 1);
        bus_write(A_DATA, 16'h7777, 5);
        bus_read(A_ADDR, d, oe1, oe2);
        n_tests++; if (d !== 16'h0202) begin $display("FAIL long_wr_addr got %h exp 0202", d); n_fail++; end
        bus_read(A_DATA, d, oe1, oe2);
        n_tests++; if (d !== 16'h1111) begin $display("FAIL long_wr_next got %h exp 1111", d); n_fail++; end
        bus_write(A_ADDR, 16'h0200, 1);
        bus_read(A_DATA, d, oe1, oe2);
        n_tests++; if (d !== 16'h7777) begin $display("FAIL long_wr_data got %h exp 7777", d); n_fail++; end
        bus_write(A_ADDR, 16'hFFFE, 1);
        bus_write(A_DATA, 16'hCAFE, 1);
        bus_read(A_ADDR, d, oe1, oe2);
        n_tests++; if (d !== 16'h0000) begin $display("FAIL wrap_addr got %h exp 0000", d); n_fail++; end
        bus_write(A_ADDR, 16'h07FE, 1);
        bus_read(A_DATA, d, oe1, oe2);
        n_tests++; if (d !== 16'hCAFE) begin $display("FAIL alias_data got %h exp CAFE", d); n_fail++; end
    endtask

    task automatic test_mbx_out;
        logic [15:0] d; logic oe1, oe2;
        pulse_out(16'hBEEF);
        n_tests++; if (hpi_int !== 1'b1 || mbx_out_full !== 1'b1) begin
            $display("FAIL mbx_out_set got int=%b full=%b exp 1 1", hpi_int, mbx_out_full); n_fail++; end
        bus_read(A_STAT, d, oe1, oe2);
        n_tests++; if (d !== 16'h0001) begin $display("FAIL mbx_out_status got %h exp 0001", d); n_fail++; end
        bus_read(A_MBX, d, oe1, oe2);
        n_tests++; if (d !== 16'hBEEF) begin $display("FAIL mbx_out_data got %h exp BEEF", d); n_fail++; end
        n_tests++; if (hpi_int !== 1'b0 || mbx_out_full !== 1'b0) begin
            $display("FAIL mbx_out_clr got int=%b full=%b exp 0 0", hpi_int, mbx_out_full); n_fail++; end
        bus_read(A_STAT, d, oe1, oe2);
        n_tests++; if (d !== 16'h0000) begin $display("FAIL mbx_out_status2 got %h exp 0000", d); n_fail++; end
    endtask

    task automatic test_mbx_collide;
        logic [15:0] d; logic oe1, oe2;
        pulse_out(16'h1111);
        pulse_out(16'h3333);
        @(negedge clk);
        hpi_address = A_MBX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        repeat (2) @(negedge clk);
        hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
        mbx_out_data = 16'h2222; mbx_out_wr = 1'b1;
        @(negedge clk);
        mbx_out_wr = 1'b0;
        n_tests++; if (mbx_out_full !== 1'b1 || hpi_int !== 1'b1) begin
            $display("FAIL collide_full got full=%b int=%b exp 1 1", mbx_out_full, hpi_int); n_fail++; end
        bus_read(A_MBX, d, oe1, oe2);
        n_tests++; if (d !== 16'h2222) begin $display("FAIL collide_data got %h exp 2222", d); n_fail++; end
        n_tests++; if (mbx_out_full !== 1'b0) begin $display("FAIL collide_clr got %b exp 0", mbx_out_full); n_fail++; end
    endtask

    task automatic test_mbx_in;
        logic [15:0] d; logic oe1, oe2;
        bus_write(A_MBX, 16'h00C3, 1);
        n_tests++; if (mbx_in_data !== 16'h00C3 || mbx_in_pending !== 1'b1) begin
            $display("FAIL mbx_in_wr got %h/%b exp 00C3/1", mbx_in_data, mbx_in_pending); n_fail++; end
        bus_read(A_STAT, d, oe1, oe2);
        n_tests++; if (d !== 16'h0002) begin $display("FAIL mbx_in_status got %h exp 0002", d); n_fail++; end
        @(negedge clk); mbx_in_ack = 1'b1;
        @(negedge clk); mbx_in_ack = 1'b0;
        n_tests++; if (mbx_in_pending !== 1'b0) begin $display("FAIL mbx_in_ack got %b exp 0", mbx_in_pending); n_fail++; end
        @(negedge clk);
        hpi_address = A_MBX; hpi_data_in = 16'h0055; hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
        repeat (2) @(negedge clk);
        hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
        @(negedge clk);
        n_tests++; if (mbx_in_data !== 16'h00C3 || mbx_in_pending !== 1'b0 || hpi_data_oe !== 1'b0) begin
            $display("FAIL both_strobes got %h/%b/%b exp 00C3/0/0", mbx_in_data, mbx_in_pending, hpi_data_oe); n_fail++; end
        @(negedge clk);
        hpi_address = A_MBX; hpi_data_in = 16'h00A5; hpi_cs_n = 1'b0; hpi_w_n = 1'b0; mbx_in_ack = 1'b1;
        @(negedge clk);
        hpi_cs_n = 1'b1; hpi_w_n = 1'b1; mbx_in_ack = 1'b0;
        n_tests++; if (mbx_in_pending !== 1'b1 || mbx_in_data !== 16'h00A5) begin
            $display("FAIL ack_vs_write got %b/%h exp 1/00A5", mbx_in_pending, mbx_in_data); n_fail++; end
        @(negedge clk); mbx_in_ack = 1'b1;
        @(negedge clk); mbx_in_ack = 1'b0;
    endtask

    task automatic test_overrun;
        logic [15:0] d; logic oe1, oe2;
        bus_write(A_MBX, 16'h0001, 1);
        bus_write(A_MBX, 16'h0002, 1);
        n_tests++; if (mbx_in_data !== 16'h0002) begin $display("FAIL ovr_overwrite got %h exp 0002", mbx_in_data); n_fail++; end
        bus_read(A_STAT, d, oe1, oe2);
`ifdef HPI_MBX_OVERRUN_EN
        n_tests++; if (d !== 16'h0006 || hpi_int !== 1'b1) begin
            $display("FAIL ovr_set got %h int=%b exp 0006 1", d, hpi_int); n_fail++; end
        bus_write(A_STAT, 16'h0004, 1);
        bus_read(A_STAT, d, oe1, oe2);
        n_tests++; if (d !== 16'h0002 || hpi_int !== 1'b0) begin
            $display("FAIL ovr_clear got %h int=%b exp 0002 0", d, hpi_int); n_fail++; end
`else
        n_tests++; if (d !== 16'h0002 || hpi_int !== 1'b0) begin
            $display("FAIL no_ovr got %h int=%b exp 0002 0", d, hpi_int); n_fail++; end
`endif
    endtask

    task automatic test_reset_mid_read;
        logic [15:0] d; logic oe1, oe2;
        pulse_out(16'h5A5A);
        @(negedge clk);
        hpi_address = A_MBX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
        @(negedge clk);
        n_tests++; if (hpi_data_oe !== 1'b1 || hpi_data_out !== 16'h5A5A) begin
            $display("FAIL pre_rst_read got %b/%h exp 1/5A5A", hpi_data_oe, hpi_data_out); n_fail++; end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({hpi_data_oe, hpi_int, mbx_out_full, mbx_in_pending, hpi_data_out, mbx_in_data} !== 36'd0) begin
            $display("FAIL async_rst got oe=%b int=%b full=%b pend=%b out=%h in=%h exp all 0",
                     hpi_data_oe, hpi_int, mbx_out_full, mbx_in_pending, hpi_data_out, mbx_in_data); n_fail++; end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (hpi_data_oe !== 1'b0) begin $display("FAIL held_strobe_no_start got %b exp 0", hpi_data_oe); n_fail++; end
        hpi_r_n = 1'b1; hpi_cs_n = 1'b1;
        bus_read(A_ADDR, d, oe1, oe2);
        n_tests++; if (d !== 16'h0000) begin $display("FAIL post_rst_addr got %h exp 0000", d); n_fail++; end
        bus_read(A_MBX, d, oe1, oe2);
        n_tests++; if (d !== 16'h0000) begin $display("FAIL post_rst_mbx got %h exp 0000", d); n_fail++; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_data_autoinc;
        test_long_write_wrap;
        test_mbx_out;
        test_mbx_collide;
        test_mbx_in;
        test_overrun;
        test_reset_mid_read;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
